// File: rtl/test_card_pkg.sv
// -----------------------------------------------------------------------------
// test_card_pkg
// Shared definitions for the animated test card: pattern mode encodings and
// the coordinate width used for x, y and the scroll offset.
// -----------------------------------------------------------------------------
package test_card_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        MODE_BORDER = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_GRAD   = 2'd3
    } mode_e;

endpackage

// File: rtl/test_card_frame_ctrl.sv
// -----------------------------------------------------------------------------
// test_card_frame_ctrl
// Holds the per-frame pattern mode and scroll offset. Both update only on the
// frame-start pulse, so the picture never changes mid-frame.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  synchronous active-low reset
//   i_frame  frame-start pulse (pixel 0,0)
//   i_mode   requested mode, sampled only with i_frame
//   o_mode   effective mode for the current pixel
//   o_off    effective scroll offset for the current pixel
// -----------------------------------------------------------------------------
module test_card_frame_ctrl
    import test_card_pkg::*;
#(
    parameter int SCROLL_STEP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame,
    input  logic [1:0]         i_mode,
    output mode_e              o_mode,
    output logic [COORD_W-1:0] o_off
);

    mode_e              mode_q, mode_d;
    logic [COORD_W-1:0] off_q, off_d;

    // The effective values are the next-state values, so the frame-start
    // pixel itself already sees the new mode and offset.
    always_comb begin
        mode_d = mode_q;
        off_d  = off_q;
        if (i_frame) begin
            mode_d = mode_e'(i_mode);
            off_d  = off_q + COORD_W'(SCROLL_STEP);
        end
        o_mode = mode_d;
        o_off  = off_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q <= MODE_BORDER;
            off_q  <= '0;
        end else begin
            mode_q <= mode_d;
            off_q  <= off_d;
        end
    end

endmodule

// File: rtl/test_card_animated.sv
// -----------------------------------------------------------------------------
// test_card_animated
// Two-stage pipelined test pattern generator: borders, colour bars, scrolling
// checkerboard or gradient, selected per frame. Latency is 2 cycles.
// Ports:
//   i_pix_clk               pixel clock
//   i_rst_n                 synchronous active-low reset
//   i_x, i_y                current pixel coordinates
//   i_de                    data enable
//   i_frame                 frame-start pulse at pixel (0,0)
//   i_mode                  requested pattern (taken at i_frame)
//   o_red, o_green, o_blue  colour channels, CB bits each
//   o_de                    i_de delayed by 2 cycles
// -----------------------------------------------------------------------------
module test_card_animated
    import test_card_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int CB          = 4,
    parameter int BW          = 16,
    parameter int CHK_LOG2    = 5,
    parameter int SCROLL_STEP = 1
) (
    input  logic               i_pix_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_de,
    input  logic               i_frame,
    input  logic [1:0]         i_mode,
    output logic [CB-1:0]      o_red,
    output logic [CB-1:0]      o_green,
    output logic [CB-1:0]      o_blue,
    output logic               o_de
);

    localparam logic [COORD_W-1:0] H_RES_C = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] V_RES_C = COORD_W'(V_RES);
    localparam logic [COORD_W-1:0] BW_C    = COORD_W'(BW);
    localparam logic [COORD_W-1:0] V_BOT_C = COORD_W'(V_RES - BW);
    localparam logic [COORD_W-1:0] H_RGT_C = COORD_W'(H_RES - BW);
    localparam int                 BAR_W   = H_RES / 8;

    function automatic logic [CB-1:0] fill(input logic b);
        return {CB{b}};
    endfunction

    mode_e              mode_eff;
    logic [COORD_W-1:0] off_eff;

    test_card_frame_ctrl #(
        .SCROLL_STEP (SCROLL_STEP)
    ) u_frame_ctrl (
        .i_clk   (i_pix_clk),
        .i_rst_n (i_rst_n),
        .i_frame (i_frame),
        .i_mode  (i_mode),
        .o_mode  (mode_eff),
        .o_off   (off_eff)
    );

    // ---------------- stage 1: predicates ----------------
    logic               vld_p1_d, vld_p1_q;
    logic               de_p1_d, de_p1_q;
    mode_e              mode_p1_d, mode_p1_q;
    logic               top_p1_d, top_p1_q;
    logic               left_p1_d, left_p1_q;
    logic               bot_p1_d, bot_p1_q;
    logic               rgt_p1_d, rgt_p1_q;
    logic [2:0]         bar_p1_d, bar_p1_q;
    logic               chk_p1_d, chk_p1_q;
    logic [CB-1:0]      grad_r_p1_d, grad_r_p1_q;
    logic [CB-1:0]      grad_g_p1_d, grad_g_p1_q;
    logic [COORD_W-1:0] xs;
    logic               unused_xs;

    always_comb begin
        xs          = i_x + off_eff;
        vld_p1_d    = i_de && (i_x < H_RES_C) && (i_y < V_RES_C);
        de_p1_d     = i_de;
        mode_p1_d   = mode_eff;
        top_p1_d    = i_y < BW_C;
        left_p1_d   = i_x < BW_C;
        bot_p1_d    = i_y >= V_BOT_C;
        rgt_p1_d    = i_x >= H_RGT_C;
        // Bar index = number of bar boundaries at or left of x.
        bar_p1_d    = '0;
        for (int k = 1; k < 8; k++) begin
            if (i_x >= COORD_W'(k * BAR_W)) bar_p1_d = bar_p1_d + 3'd1;
        end
        chk_p1_d    = xs[CHK_LOG2] ^ i_y[CHK_LOG2];
        grad_r_p1_d = xs[CB+1:2];
        grad_g_p1_d = i_y[CB+1:2];
    end

    assign unused_xs = ^xs;

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            vld_p1_q <= 1'b0;
            de_p1_q  <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            de_p1_q  <= de_p1_d;
        end
        mode_p1_q   <= mode_p1_d;
        top_p1_q    <= top_p1_d;
        left_p1_q   <= left_p1_d;
        bot_p1_q    <= bot_p1_d;
        rgt_p1_q    <= rgt_p1_d;
        bar_p1_q    <= bar_p1_d;
        chk_p1_q    <= chk_p1_d;
        grad_r_p1_q <= grad_r_p1_d;
        grad_g_p1_q <= grad_g_p1_d;
    end

    // ---------------- stage 2: colour select ----------------
    logic [CB-1:0] red_p2_d, red_p2_q;
    logic [CB-1:0] grn_p2_d, grn_p2_q;
    logic [CB-1:0] blu_p2_d, blu_p2_q;
    logic          de_p2_q;

    always_comb begin
        red_p2_d = '0;
        grn_p2_d = '0;
        blu_p2_d = '0;
        if (vld_p1_q) begin
            case (mode_p1_q)
                MODE_BORDER: begin
                    red_p2_d = fill(top_p1_q | left_p1_q);
                    grn_p2_d = fill(top_p1_q | bot_p1_q);
                    blu_p2_d = fill(top_p1_q | rgt_p1_q);
                end
                MODE_BARS: begin
                    red_p2_d = fill(~bar_p1_q[2]);
                    grn_p2_d = fill(~bar_p1_q[1]);
                    blu_p2_d = fill(~bar_p1_q[0]);
                end
                MODE_CHECK: begin
                    red_p2_d = fill(chk_p1_q);
                    grn_p2_d = fill(chk_p1_q);
                    blu_p2_d = fill(chk_p1_q);
                end
                MODE_GRAD: begin
                    red_p2_d = grad_r_p1_q;
                    grn_p2_d = grad_g_p1_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            red_p2_q <= '0;
            grn_p2_q <= '0;
            blu_p2_q <= '0;
            de_p2_q  <= 1'b0;
        end else begin
            red_p2_q <= red_p2_d;
            grn_p2_q <= grn_p2_d;
            blu_p2_q <= blu_p2_d;
            de_p2_q  <= de_p1_q;
        end
    end

    assign o_red   = red_p2_q;
    assign o_green = grn_p2_q;
    assign o_blue  = blu_p2_q;
    assign o_de    = de_p2_q;

endmodule

// File: tb/tb_test_card_animated.sv
module tb_test_card_animated;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int CB       = 4;
    localparam int BW       = 16;
    localparam int CHK_LOG2 = 5;
    localparam int STEP     = 1;
    localparam logic [CB-1:0] F = 4'hF;

    typedef struct packed {
        logic [CB-1:0] r;
        logic [CB-1:0] g;
        logic [CB-1:0] b;
        logic          de;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        logic       de;
        logic       fr;
        logic [1:0] md;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   i_x = '0;
    logic [15:0]   i_y = '0;
    logic          i_de = 1'b0;
    logic          i_frame = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [CB-1:0] o_red, o_green, o_blue;
    logic          o_de;

    int n_run = 0;
    int n_fail = 0;

    exp_t        q[$];
    logic [1:0]  m_mode = '0;
    logic [15:0] m_off = '0;

    test_card_animated #(
        .H_RES(H_RES), .V_RES(V_RES), .CB(CB), .BW(BW),
        .CHK_LOG2(CHK_LOG2), .SCROLL_STEP(STEP)
    ) dut (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_de      (i_de),
        .i_frame   (i_frame),
        .i_mode    (i_mode),
        .o_red     (o_red),
        .o_green   (o_green),
        .o_blue    (o_blue),
        .o_de      (o_de)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int x, input int y, input logic de,
                                   input logic [1:0] m, input logic [15:0] off);
        exp_t        r;
        logic [15:0] xs;
        int          bar;
        logic        wh;
        r    = '0;
        r.de = de;
        if (!de || x >= H_RES || y >= V_RES) return r;
        xs = 16'(x) + off;
        case (m)
            2'd0: begin
                r.r = (y < BW || x < BW) ? F : '0;
                r.g = (y < BW || y >= V_RES - BW) ? F : '0;
                r.b = (y < BW || x >= H_RES - BW) ? F : '0;
            end
            2'd1: begin
                bar = x / (H_RES / 8);
                r.r = bar[2] ? '0 : F;
                r.g = bar[1] ? '0 : F;
                r.b = bar[0] ? '0 : F;
            end
            2'd2: begin
                wh  = xs[CHK_LOG2] ^ (((y >> CHK_LOG2) & 1) == 1);
                r.r = wh ? F : '0;
                r.g = wh ? F : '0;
                r.b = wh ? F : '0;
            end
            default: begin
                r.r = CB'(xs >> 2);
                r.g = CB'(y >> 2);
            end
        endcase
        return r;
    endfunction

    task automatic drive(input pix_t p);
        i_x     = 16'(p.x);
        i_y     = 16'(p.y);
        i_de    = p.de;
        i_frame = p.fr;
        i_mode  = p.md;
        if (p.fr) begin
            m_mode = p.md;
            m_off  = m_off + 16'(STEP);
        end
        q.push_back(model(p.x, p.y, p.de, m_mode, m_off));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        m_mode = '0;
        m_off  = '0;
        rst_n  = 1'b1;
        q.push_back('0);
    endtask

    function automatic pix_t px(input int x, input int y, input logic de,
                                input logic fr, input logic [1:0] md);
        pix_t p;
        p.x = x; p.y = y; p.de = de; p.fr = fr; p.md = md;
        return p;
    endfunction

    task automatic test_reset();
        pix_t s[$];
        exp_t e;
        rst_n = 1'b0; i_de = 1'b1; i_x = '0; i_y = '0; i_mode = 2'd1; i_frame = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_run++;
            if ({o_red, o_green, o_blue, o_de} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got r=%h g=%h b=%h de=%b, expected all 0",
                         i, o_red, o_green, o_blue, o_de);
            end
        end
        q.delete(); m_mode = '0; m_off = '0;
        rst_n = 1'b1;
        q.push_back('0);
        s = '{px(0, 0, 1, 0, 0), px(0, 0, 0, 0, 0), px(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL reset step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
            if (i == 1) begin
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== {F, F, F, 1'b1}) begin
                    n_fail++;
                    $display("FAIL reset_white: got r=%h g=%h b=%h de=%b, expected F/F/F de=1",
                             o_red, o_green, o_blue, o_de);
                end
            end
        end
    endtask

    task automatic test_borders();
        pix_t s[$];
        exp_t e;
        do_reset();
        s = '{px(0, 0, 1, 1, 0), px(5, 100, 1, 0, 0), px(100, 470, 1, 0, 0),
              px(630, 100, 1, 0, 0), px(630, 470, 1, 0, 0), px(100, 100, 1, 0, 0),
              px(639, 479, 1, 0, 0), px(15, 15, 1, 0, 0), px(16, 16, 1, 0, 0),
              px(624, 464, 1, 0, 0), px(623, 463, 1, 0, 0), px(100, 10, 0, 0, 0),
              px(0, 0, 0, 0, 0), px(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL borders step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
        end
    endtask

    task automatic test_bars();
        pix_t s[$];
        exp_t e;
        s = '{px(0, 0, 1, 1, 1), px(80, 0, 1, 0, 1), px(560, 0, 1, 0, 1),
              px(80, 5, 1, 0, 0), px(79, 3, 1, 0, 0), px(639, 3, 1, 0, 2),
              px(320, 3, 1, 0, 3), px(640, 10, 1, 0, 1), px(10, 480, 1, 0, 1),
              px(0, 0, 0, 0, 0), px(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL bars step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
        end
    endtask

    task automatic test_check_back_to_back();
        pix_t s[$];
        exp_t e;
        do_reset();
        s = '{px(0, 0, 1, 1, 2), px(31, 0, 1, 0, 2), px(30, 0, 1, 0, 2),
              px(31, 32, 1, 0, 2), px(63, 0, 1, 0, 2),
              px(0, 0, 1, 1, 2), px(0, 0, 1, 1, 2), px(29, 0, 1, 0, 2),
              px(28, 0, 1, 0, 2), px(0, 0, 0, 0, 0), px(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL check step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
        end
    endtask

    task automatic test_grad();
        pix_t s[$];
        exp_t e;
        do_reset();
        s = '{px(0, 0, 1, 1, 3), px(19, 40, 1, 0, 3), px(63, 0, 1, 0, 3),
              px(600, 479, 1, 0, 3), px(0, 0, 0, 0, 0), px(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL grad step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
            if (i == 2) begin
                n_run++;
                if ({o_red, o_green, o_blue} !== {4'd5, 4'd10, 4'd0}) begin
                    n_fail++;
                    $display("FAIL grad_point: got r=%0d g=%0d b=%0d, expected 5/10/0",
                             o_red, o_green, o_blue);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        pix_t s[$];
        exp_t e;
        do_reset();
        s = '{px(0, 0, 1, 1, 2), px(0, 0, 1, 1, 2), px(0, 0, 1, 1, 2),
              px(100, 7, 1, 0, 2), px(101, 7, 1, 0, 2)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL midrst_pre step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
        end
        rst_n = 1'b0; i_x = 16'd102; i_de = 1'b1;
        @(posedge clk); #1;
        n_run++;
        if ({o_red, o_green, o_blue, o_de} !== 13'd0) begin
            n_fail++;
            $display("FAIL midrst_flush: got r=%h g=%h b=%h de=%b, expected all 0",
                     o_red, o_green, o_blue, o_de);
        end
        q.delete(); m_mode = '0; m_off = '0;
        rst_n = 1'b1;
        q.push_back('0);
        s = '{px(31, 0, 1, 0, 2), px(31, 100, 1, 0, 2), px(31, 0, 1, 1, 2),
              px(30, 0, 1, 0, 2), px(0, 0, 0, 0, 0), px(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL midrst_post step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
        end
    endtask

    task automatic test_random();
        pix_t p;
        exp_t e;
        for (int i = 0; i < 400; i++) begin
            p = px(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                   $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                   2'($urandom_range(0, 3)));
            if (i >= 398) p.de = 1'b0;
            drive(p);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_run++;
                if ({o_red, o_green, o_blue, o_de} !== e) begin
                    n_fail++;
                    $display("FAIL random step %0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             i, o_red, o_green, o_blue, o_de, e.r, e.g, e.b, e.de);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_borders();
        test_bars();
        test_check_back_to_back();
        test_grad();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
